wb_commit_queue: RTL
====================

// Module: wb_commit_queue
// PURPOSE
//  In-order writeback/commit stage directly upstream of the 32x64 GPR file. Decode allocates
//  one slot per instruction in program order; execute/memory units complete slots out of order
//  by tag; the head slot retires in order and drives the regfile write port. A per-register
//  busy scoreboard answers two read-port hazard queries for decode.
// PARAMETERS
//  DEPTH   4    slots in queue; power of 2, >=2
//  XLEN    64   data width; equals regfile width
//  TAG_W   $clog2(DEPTH)  slot tag width (derived, not overridable)
// PORTS
//  clock        in   1      clock; all state updates on posedge
//  reset        in   1      asynchronous, active-low reset
//  flush        in   1      discard all uncommitted slots
//  alloc_valid  in   1      decode requests a slot
//  alloc_rd     in   5      destination register (0 = no write)
//  alloc_ready  out  1      slot available; handshake = alloc_valid & alloc_ready
//  alloc_tag    out  TAG_W  tag of slot granted this cycle (= tail pointer)
//  cmpl_valid   in   1      a functional unit delivers a result
//  cmpl_tag     in   TAG_W  slot being completed
//  cmpl_data    in   XLEN   result value
//  cmpl_err     out  1      registered 1-cycle pulse: completion ignored (bad tag)
//  qry_rs1      in   5      hazard query, source 1
//  qry_rs2      in   5      hazard query, source 2
//  qry_busy1    out  1      rs1 has a pending or not-yet-written producer (comb)
//  qry_busy2    out  1      same for rs2
//  rf_wen       out  1      regfile write enable (registered)
//  rf_waddr     out  5      regfile write address (registered)
//  rf_wdata     out  XLEN   regfile write data (registered)
// BEHAVIOUR
//  - Reset (reset=0, async): head=tail=0, count=0, all valid/done/busy/owner cleared;
//    rf_wen=0, rf_waddr=0, rf_wdata=0, cmpl_err=0. alloc_ready=1 after reset release.
//  - Slot = {valid, done, rd[4:0], data[XLEN-1:0]}. Pointers wrap modulo DEPTH; count 0..DEPTH.
//  - alloc_ready = (count != DEPTH) & ~flush; does NOT depend on a same-cycle pop.
//  - Alloc edge: slot[tail] <= {1,0,alloc_rd,x}; tail++; if alloc_rd!=0: busy[rd]<=1, owner[rd]<=tail.
//  - Completion: accepted iff slot[cmpl_tag].valid & ~done -> done<=1, data<=cmpl_data.
//    Otherwise ignored and cmpl_err<=1 for one cycle. Completion never aliases into a new alloc.
//  - Pop: when slot[head].valid & done (state as of start of cycle): slot invalidated, head++,
//    rf_wen<=(rd!=0), rf_waddr<=rd, rf_wdata<=data. No pop -> rf_wen<=0 (addr/data hold).
//    At most one pop per cycle. Min latency: cmpl at edge k -> rf_wen high cycle k+1 -> GPR
//    written at edge k+2.
//  - Busy clear at pop edge only if busy[rd] & owner[rd]==head; a younger writer of same rd
//    keeps busy=1. Same-cycle alloc of that rd wins (busy stays 1, owner = new tag).
//  - qry_busyN = (rsN!=0) & (busy[rsN] | (rf_wen & rf_waddr==rsN)); covers the in-flight write.
//  - Simultaneous alloc+pop: count unchanged. Alloc+completion of same slot is illegal (tag
//    not yet issued -> treated as bad tag).
//  - Flush (sync): all slots valid<=0, busy<=0, head=tail=0, count=0; the rf_* register already
//    loaded still completes its write. Flush overrides alloc, completion and pop that cycle.
//  - Reset asserted mid-operation: all state cleared immediately, pending write dropped.
// CONFIGURATION
//  WBQ_FWD_EN defined: adds outputs qry_fwd1/qry_fwd2 (1) and qry_data1/qry_data2 (XLEN).
//   If rsN's newest producer is done (owner slot done, or the rf_* register matches and is the
//   newest), fwd=1, data=that value, busy=0. Otherwise fwd=0, data=0.
//  WBQ_FWD_EN undefined: those ports absent; busy as defined above; no data path to decode.
// TESTING
//  1 Reset: assert reset=0 mid-traffic -> rf_wen=0, alloc_ready=1, qry_busy1=0 for rs=5 on release.
//  2 Alloc rd=5 (tag0), complete tag0 data=0xDEAD -> rf_wen=1,waddr=5,wdata=0xDEAD 2 edges later;
//    qry_busy1(rs1=5)=1 until edge after rf_wen cycle, then 0.
//  3 Out-of-order: alloc rd=1,2,3 tags0-2; complete 2,1,0 -> writes to x1,x2,x3 in that order,
//    consecutive cycles.
//  4 Full/wrap: DEPTH=4 allocs -> alloc_ready=0; one pop -> ready=1, next alloc_tag=0.
//  5 WAW: alloc rd=7 tags0,1; complete tag0 -> busy(7) stays 1; complete tag1 -> clears after pop.
//  6 Flush with 3 pending + bad tag 3 completion -> cmpl_err pulse, busy all 0, alloc_tag=0 next;
//    with WBQ_FWD_EN, done rd=9 data=0x42 pending -> qry_fwd1=1, qry_data1=0x42, busy1=0.

Source files
------------

// File: rtl/wb_commit_queue_if.sv
// ---------------------------------------------------------------------------
// wb_commit_queue_if
//   Bundles every non-clock/reset signal of wb_commit_queue.
//   master : decode / functional-unit side (drives allocs, completions,
//            hazard queries; observes the regfile write port)
//   slave  : the commit queue itself
//   Signals:
//     flush                         discard all uncommitted slots
//     alloc_valid/alloc_rd          slot request + destination register
//     alloc_ready/alloc_tag         slot available + granted tag (tail)
//     cmpl_valid/cmpl_tag/cmpl_data result delivery by tag
//     cmpl_err                      registered pulse: completion ignored
//     qry_rs1/qry_rs2               hazard query registers
//     qry_busy1/qry_busy2           register has a pending producer
//     rf_wen/rf_waddr/rf_wdata      registered regfile write port
//   Optional (WBQ_FWD_EN defined): qry_fwd1/2, qry_data1/2 forwarding.
// ---------------------------------------------------------------------------
interface wb_commit_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
);
  localparam int TAG_W = $clog2(DEPTH);

  logic             flush;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cmpl_valid;
  logic [TAG_W-1:0] cmpl_tag;
  logic [XLEN-1:0]  cmpl_data;
  logic             cmpl_err;
  logic [4:0]       qry_rs1;
  logic [4:0]       qry_rs2;
  logic             qry_busy1;
  logic             qry_busy2;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
`ifdef WBQ_FWD_EN
  logic             qry_fwd1;
  logic             qry_fwd2;
  logic [XLEN-1:0]  qry_data1;
  logic [XLEN-1:0]  qry_data2;
`endif

  modport master (
    output flush, alloc_valid, alloc_rd, cmpl_valid, cmpl_tag, cmpl_data, qry_rs1, qry_rs2,
`ifdef WBQ_FWD_EN
    input  qry_fwd1, qry_fwd2, qry_data1, qry_data2,
`endif
    input  alloc_ready, alloc_tag, cmpl_err, qry_busy1, qry_busy2, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  flush, alloc_valid, alloc_rd, cmpl_valid, cmpl_tag, cmpl_data, qry_rs1, qry_rs2,
`ifdef WBQ_FWD_EN
    output qry_fwd1, qry_fwd2, qry_data1, qry_data2,
`endif
    output alloc_ready, alloc_tag, cmpl_err, qry_busy1, qry_busy2, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_commit_queue.sv
// ---------------------------------------------------------------------------
// wb_commit_queue
//   In-order writeback/commit queue in front of the 32 x XLEN GPR file.
//   Decode allocates slots in program order, functional units complete them
//   out of order by tag, and the head slot retires into the registered
//   regfile write port. A per-register busy scoreboard (busy + owner tag)
//   answers two hazard queries for decode.
//   Ports:
//     clock  posedge clock
//     reset  asynchronous, active-low reset
//     bus    wb_commit_queue_if.slave (alloc / completion / query / rf write)
//   Parameters: DEPTH (power of 2, >= 2), XLEN.
//   Optional feature macro: WBQ_FWD_EN -- forwards a finished producer's
//   value to decode through qry_fwdN/qry_dataN and drops its busy flag.
// ---------------------------------------------------------------------------
module wb_commit_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic             clock,
  input  logic             reset,
  wb_commit_queue_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 32;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [4:0]       reg_t;

  // Slot control bits (reset) and payload (not reset).
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_done;
  reg_t             slot_rd   [DEPTH];
  logic [XLEN-1:0]  slot_data [DEPTH];

  tag_t             head;
  tag_t             tail;
  logic [CNT_W-1:0] count;

  // Scoreboard: busy[r] means some valid slot will write r; owner[r] is the
  // youngest such slot.
  logic [NREG-1:0]  busy;
  tag_t             owner [NREG];

  logic             rf_wen;
  reg_t             rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             cmpl_err;

  logic             alloc_ready;
  logic             alloc_fire;
  logic             pop;
  logic             cmpl_ok;
  logic             busy_clear;
  reg_t             head_rd;
  logic [XLEN-1:0]  head_data;

  // Readiness looks only at the current count, never at a same-cycle pop,
  // which keeps alloc_ready off the completion/pop timing path.
  assign alloc_ready = (count != CNT_W'(DEPTH)) & ~bus.flush;
  assign alloc_fire  = bus.alloc_valid & alloc_ready;

  assign head_rd   = slot_rd[head];
  assign head_data = slot_data[head];
  assign pop       = slot_valid[head] & slot_done[head] & ~bus.flush;

  // A tag that is not yet issued (including this cycle's tail) is not valid,
  // so completion can never alias into a slot allocated this cycle.
  assign cmpl_ok = bus.cmpl_valid & ~bus.flush
                 & slot_valid[bus.cmpl_tag] & ~slot_done[bus.cmpl_tag];

  // Only the youngest writer of a register may clear its busy flag.
  assign busy_clear = pop & (head_rd != '0) & busy[head_rd] & (owner[head_rd] == head);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the state as of the start of the cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      slot_valid <= '0;
      slot_done  <= '0;
      busy       <= '0;
      for (int i = 0; i < NREG; i++) owner[i] <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      cmpl_err   <= 1'b0;
    end else if (bus.flush) begin
      // The rf_* register keeps its address/data; a write already presented
      // this cycle still lands in the regfile.
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      slot_valid <= '0;
      slot_done  <= '0;
      busy       <= '0;
      rf_wen     <= 1'b0;
      cmpl_err   <= 1'b0;
    end else begin
      cmpl_err <= bus.cmpl_valid & ~cmpl_ok;
      rf_wen   <= pop & (head_rd != '0);

      if (pop) begin
        slot_valid[head] <= 1'b0;
        head             <= head + tag_t'(1);
        rf_waddr         <= head_rd;
        rf_wdata         <= head_data;
      end

      if (cmpl_ok) slot_done[bus.cmpl_tag] <= 1'b1;

      if (alloc_fire) begin
        slot_valid[tail] <= 1'b1;
        slot_done[tail]  <= 1'b0;
        tail             <= tail + tag_t'(1);
      end

      if (alloc_fire && !pop)      count <= count + CNT_W'(1);
      else if (pop && !alloc_fire) count <= count - CNT_W'(1);

      // Ordering matters: a same-cycle alloc of the retiring register is
      // written last, so it keeps busy set and takes ownership.
      if (busy_clear) busy[head_rd] <= 1'b0;
      if (alloc_fire && (bus.alloc_rd != '0)) begin
        busy[bus.alloc_rd]  <= 1'b1;
        owner[bus.alloc_rd] <= tail;
      end
    end
  end

  // NOTE: the payload array has no reset; slot_valid/slot_done gate every
  // use of it, so clearing it would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (alloc_fire) slot_rd[tail]           <= bus.alloc_rd;
    if (cmpl_ok)    slot_data[bus.cmpl_tag] <= bus.cmpl_data;
  end

  // Busy also covers the write sitting in the rf_* register, which the
  // regfile has not absorbed yet.
  function automatic logic base_busy(input reg_t rs);
    return (rs != '0) & (busy[rs] | (rf_wen & (rf_waddr == rs)));
  endfunction

`ifdef WBQ_FWD_EN
  typedef struct packed {
    logic            busy;
    logic            fwd;
    logic [XLEN-1:0] data;
  } qry_t;

  // Newest producer first: the owner slot if one is pending, otherwise the
  // in-flight regfile write (busy is already clear for that register).
  function automatic qry_t fwd_lookup(input reg_t rs);
    qry_t r;
    r      = '0;
    r.busy = base_busy(rs);
    if (rs != '0) begin
      if (busy[rs]) begin
        if (slot_done[owner[rs]]) begin
          r.fwd  = 1'b1;
          r.data = slot_data[owner[rs]];
        end
      end else if (rf_wen && (rf_waddr == rs)) begin
        r.fwd  = 1'b1;
        r.data = rf_wdata;
      end
      if (r.fwd) r.busy = 1'b0;
    end
    return r;
  endfunction

  qry_t q1;
  qry_t q2;

  // NOTE: every always_comb output gets a value on every path (here by
  // whole-struct assignment) so no latch can be inferred.
  always_comb begin
    q1 = fwd_lookup(bus.qry_rs1);
    q2 = fwd_lookup(bus.qry_rs2);
  end

  assign bus.qry_busy1 = q1.busy;
  assign bus.qry_busy2 = q2.busy;
  assign bus.qry_fwd1  = q1.fwd;
  assign bus.qry_fwd2  = q2.fwd;
  assign bus.qry_data1 = q1.data;
  assign bus.qry_data2 = q2.data;
`else
  assign bus.qry_busy1 = base_busy(bus.qry_rs1);
  assign bus.qry_busy2 = base_busy(bus.qry_rs2);
`endif

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail;
  assign bus.cmpl_err    = cmpl_err;
  assign bus.rf_wen      = rf_wen;
  assign bus.rf_waddr    = rf_waddr;
  assign bus.rf_wdata    = rf_wdata;

endmodule
